// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: PC source encodings,
// mult/div FSM state codes and the default register address width.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [2:0] PC_SEQ = 3'd0;
    localparam logic [2:0] PC_BR  = 3'd1;
    localparam logic [2:0] PC_J   = 3'd2;
    localparam logic [2:0] PC_JR  = 3'd3;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/EX observation inputs and pipeline control outputs between
// the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [2:0]       PCSrc;
    logic             Branch;
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UseRs;
    logic             ID_UseRt;
    logic             ID_MulDiv;
    logic             ID_ReadHiLo;
    logic [REG_W-1:0] EX_Rt;
    logic             EX_MemRd;
    logic             Mem_Busy;

    logic             IF_ID_Stall;
    logic             IF_ID_Hold;
    logic             ID_EX_Stall;
    logic             PCHold;
    logic             PipeFreeze;
    logic             MD_Busy;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output PCSrc, Branch, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_MulDiv,
               ID_ReadHiLo, EX_Rt, EX_MemRd, Mem_Busy,
        input  IF_ID_Stall, IF_ID_Hold, ID_EX_Stall, PCHold, PipeFreeze,
               MD_Busy, StallCycles
    );

    modport slave (
        input  PCSrc, Branch, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_MulDiv,
               ID_ReadHiLo, EX_Rt, EX_MemRd, Mem_Busy,
        output IF_ID_Stall, IF_ID_Hold, ID_EX_Stall, PCHold, PipeFreeze,
               MD_Busy, StallCycles
    );

endinterface

// File: rtl/hazard_ctrl_load_scoreboard.sv
// Pending-load scoreboard: tracks loads that have left EX but whose data is
// not yet available, and flags an ID instruction that reads one of them.
// With LOAD_LATENCY=1 the single entry is tied invalid, so only the direct
// EX-stage compare remains and the registers optimise away.
module hazard_ctrl_load_scoreboard #(
    parameter int LOAD_LATENCY = 1,
    parameter int REG_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    output logic             load_haz
);

    localparam int DEPTH = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 1 : 1;

    logic [DEPTH-1:0] sb_valid;
    logic [REG_W-1:0] sb_reg [DEPTH];
    logic             sb_hit;

    function automatic logic src_match(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic             use_rt,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] r
    );
        return (r != '0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

    // Shift the load pipeline each unfrozen cycle; the oldest entry falls off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            for (int i = 0; i < DEPTH; i++) sb_reg[i] <= '0;
        end else if (!freeze) begin
            sb_valid[0] <= (LOAD_LATENCY > 1) && ex_memrd && (ex_rt != '0);
            sb_reg[0]   <= ex_rt;
            for (int i = 1; i < DEPTH; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_reg[i]   <= sb_reg[i-1];
            end
        end
    end

    // Any valid pending load whose destination the ID instruction reads.
    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (sb_valid[i] && src_match(id_use_rs, id_rs, id_use_rt, id_rt, sb_reg[i]))
                sb_hit = 1'b1;
    end

    assign load_haz = (ex_memrd && src_match(id_use_rs, id_rs, id_use_rt, id_rt, ex_rt))
                    || sb_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside the ID stage: load-use and HI/LO busy
// stalls, jump/branch flushes, memory-wait freezes and a stall counter.
//
// Mult/div FSM states:
//   state   | meaning
//   MD_IDLE | no mult/div in flight; HI/LO readable
//   MD_BUSY | mult/div running; md_cnt holds remaining busy cycles
module hazard_ctrl #(
    parameter int LOAD_LATENCY = 1,
    parameter int MD_LATENCY   = 4,
    parameter int REG_W        = hazard_ctrl_pkg::REG_W,
    parameter int CNT_W        = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    import hazard_ctrl_pkg::PC_BR;
    import hazard_ctrl_pkg::PC_J;
    import hazard_ctrl_pkg::PC_JR;
    import hazard_ctrl_pkg::MD_IDLE;
    import hazard_ctrl_pkg::MD_BUSY;

    localparam int MD_CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    logic             load_haz;
    logic             md_haz;
    logic             haz;
    logic             md_start;
    logic [0:0]       md_state;
    logic [MD_CW-1:0] md_cnt;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl_load_scoreboard #(
        .LOAD_LATENCY(LOAD_LATENCY),
        .REG_W       (REG_W)
    ) u_load_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .freeze   (bus.PipeFreeze),
        .ex_memrd (bus.EX_MemRd),
        .ex_rt    (bus.EX_Rt),
        .id_rs    (bus.ID_Rs),
        .id_rt    (bus.ID_Rt),
        .id_use_rs(bus.ID_UseRs),
        .id_use_rt(bus.ID_UseRt),
        .load_haz (load_haz)
    );

    assign md_haz   = (md_state == MD_BUSY) && (bus.ID_MulDiv || bus.ID_ReadHiLo);
    assign haz      = load_haz || md_haz;
    assign md_start = bus.ID_MulDiv && !haz && !bus.Mem_Busy && (MD_LATENCY > 1);

    // Priority decode: freeze, then stall, then flush; stalls beat flushes so
    // the branch/jump simply re-resolves once the stall clears.
    always_comb begin
        bus.IF_ID_Stall = 1'b0;
        bus.IF_ID_Hold  = 1'b0;
        bus.ID_EX_Stall = 1'b0;
        bus.PCHold      = 1'b0;
        bus.PipeFreeze  = 1'b0;
        if (reset) begin
            bus.PipeFreeze = 1'b0;
        end else if (bus.Mem_Busy) begin
            bus.PipeFreeze = 1'b1;
            bus.PCHold     = 1'b1;
            bus.IF_ID_Hold = 1'b1;
        end else if (haz) begin
            bus.PCHold      = 1'b1;
            bus.IF_ID_Hold  = 1'b1;
            bus.ID_EX_Stall = 1'b1;
        end else if ((bus.PCSrc == PC_J) || (bus.PCSrc == PC_JR)
                  || (bus.PCSrc == PC_BR) || bus.Branch) begin
            bus.IF_ID_Stall = 1'b1;
        end
    end

    // Mult/div busy tracker; keeps counting through freezes since the unit
    // runs on its own. BUSY lasts MD_LATENCY-1 cycles: it drops on the edge
    // where the counter reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else if (md_state == MD_IDLE) begin
            if (md_start) begin
                md_state <= MD_BUSY;
                md_cnt   <= MD_CW'(MD_LATENCY - 1);
            end
        end else if (md_cnt <= MD_CW'(1)) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_cnt <= md_cnt - MD_CW'(1);
        end
    end

    // Performance counter of PC-hold cycles, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           stall_cnt <= '0;
        else if (bus.PCHold) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign bus.MD_Busy     = (md_state == MD_BUSY);
    assign bus.StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances with LOAD_LATENCY 1/2/3 share one
// stimulus stream; each check targets the instance whose latency it needs.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] pcsrc;
        logic       branch;
        logic [4:0] rs;
        logic       use_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       muldiv;
        logic       readhilo;
        logic [4:0] ex_rt;
        logic       ex_memrd;
        logic       mem_busy;
    } in_t;

    typedef struct packed {
        logic if_id_stall;
        logic if_id_hold;
        logic id_ex_stall;
        logic pchold;
        logic pipefreeze;
        logic md_busy;
    } out_t;

    typedef struct {
        in_t   in;
        out_t  exp;
        string name;
    } vec_t;

    typedef struct {
        out_t  exp;
        int    inst;
        string name;
    } sb_t;

    in_t         vin;
    out_t        o   [3];
    logic [31:0] cnt [3];
    sb_t         q   [$];
    int          checks = 0;
    int          passes = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();
        assign bus.PCSrc       = vin.pcsrc;
        assign bus.Branch      = vin.branch;
        assign bus.ID_Rs       = vin.rs;
        assign bus.ID_Rt       = vin.rt;
        assign bus.ID_UseRs    = vin.use_rs;
        assign bus.ID_UseRt    = vin.use_rt;
        assign bus.ID_MulDiv   = vin.muldiv;
        assign bus.ID_ReadHiLo = vin.readhilo;
        assign bus.EX_Rt       = vin.ex_rt;
        assign bus.EX_MemRd    = vin.ex_memrd;
        assign bus.Mem_Busy    = vin.mem_busy;
        assign o[g]   = {bus.IF_ID_Stall, bus.IF_ID_Hold, bus.ID_EX_Stall,
                         bus.PCHold, bus.PipeFreeze, bus.MD_Busy};
        assign cnt[g] = bus.StallCycles;
        hazard_ctrl #(
            .LOAD_LATENCY(g + 1),
            .MD_LATENCY  (4),
            .REG_W       (5),
            .CNT_W       (32)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    function automatic in_t mk(input logic [2:0] pc, input logic br,
                               input logic [4:0] rs, input logic ur,
                               input logic [4:0] rt, input logic ut,
                               input logic md, input logic hl,
                               input logic [4:0] ert, input logic emr,
                               input logic mb);
        in_t v;
        v.pcsrc = pc;  v.branch = br;   v.rs = rs;     v.use_rs = ur;
        v.rt = rt;     v.use_rt = ut;   v.muldiv = md; v.readhilo = hl;
        v.ex_rt = ert; v.ex_memrd = emr; v.mem_busy = mb;
        return v;
    endfunction

    // Drive one cycle, queue the expectation, compare at the falling edge.
    task automatic step(input in_t v, input out_t e, input int inst, input string nm);
        sb_t s;
        sb_t g;
        vin    = v;
        s.exp  = e;
        s.inst = inst;
        s.name = nm;
        q.push_back(s);
        @(negedge clk);
        g = q.pop_front();
        checks++;
        if (o[g.inst] === g.exp) passes++;
        else $display("FAIL %s: got %b want %b (inst LL=%0d)", g.name, o[g.inst], g.exp, g.inst + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int inst, input logic [31:0] e, input string nm);
        checks++;
        if (cnt[inst] === e) passes++;
        else $display("FAIL %s: StallCycles got %0d want %0d", nm, cnt[inst], e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vin   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl [13];
    int   exp_hold;

    initial begin
        tbl[0]  = '{mk(PC_SEQ,0, 0,0, 0,0, 0,0, 0,0, 0), 6'b000000, "idle"};
        tbl[1]  = '{mk(PC_SEQ,0, 8,1, 0,0, 0,0, 8,1, 0), 6'b011100, "lu_rs"};
        tbl[2]  = '{mk(PC_SEQ,0, 0,1, 0,0, 0,0, 0,1, 0), 6'b000000, "lu_r0"};
        tbl[3]  = '{mk(PC_SEQ,0, 0,0, 8,1, 0,0, 8,1, 0), 6'b011100, "lu_rt"};
        tbl[4]  = '{mk(PC_SEQ,0, 8,0, 0,0, 0,0, 8,1, 0), 6'b000000, "lu_unused"};
        tbl[5]  = '{mk(PC_J,  0, 8,1, 0,0, 0,0, 8,1, 0), 6'b011100, "lu_over_j"};
        tbl[6]  = '{mk(PC_J,  0, 0,0, 0,0, 0,0, 0,0, 0), 6'b100000, "jump"};
        tbl[7]  = '{mk(PC_JR, 0, 0,0, 0,0, 0,0, 0,0, 0), 6'b100000, "jr"};
        tbl[8]  = '{mk(PC_BR, 0, 0,0, 0,0, 0,0, 0,0, 0), 6'b100000, "br_pcsrc"};
        tbl[9]  = '{mk(PC_SEQ,1, 0,0, 0,0, 0,0, 0,0, 0), 6'b100000, "branch"};
        tbl[10] = '{mk(PC_J,  0, 8,1, 0,0, 0,0, 8,1, 1), 6'b010110, "freeze_pri"};
        tbl[11] = '{mk(PC_SEQ,0, 9,1, 0,0, 0,0, 8,1, 0), 6'b000000, "lu_nomatch"};
        tbl[12] = '{mk(3'd4,  0, 0,0, 0,0, 0,0, 0,0, 0), 6'b000000, "pcsrc4"};

        // Outputs held at zero while reset is high, even with a hazard present.
        reset = 1'b1;
        vin   = '0;
        @(posedge clk);
        #1;
        step(mk(PC_J,0, 8,1, 0,0, 1,1, 8,1, 0), 6'b000000, 0, "rst_out");
        chk_cnt(0, 0, "rst_cnt");
        reset = 1'b0;

        // Single-cycle priority and match vectors on LOAD_LATENCY=1.
        exp_hold = 0;
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in, tbl[i].exp, 0, tbl[i].name);
            if (tbl[i].exp.pchold) exp_hold++;
        end
        chk_cnt(0, exp_hold, "tbl_cnt");

        // LOAD_LATENCY=3: three-cycle load-use stall.
        do_reset();
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 9,1, 0), 6'b011100, 2, "ll3_c0");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 0,0, 0), 6'b011100, 2, "ll3_c1");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 0,0, 0), 6'b011100, 2, "ll3_c2");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 0,0, 0), 6'b000000, 2, "ll3_c3");
        chk_cnt(2, 3, "ll3_cnt");

        // LOAD_LATENCY=2: freeze for two cycles with the load in EX.
        do_reset();
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 9,1, 1), 6'b010110, 1, "frz_c0");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 9,1, 1), 6'b010110, 1, "frz_c1");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 9,1, 0), 6'b011100, 1, "frz_c2");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 0,0, 0), 6'b011100, 1, "frz_c3");
        step(mk(PC_SEQ,0, 9,1, 0,0, 0,0, 0,0, 0), 6'b000000, 1, "frz_c4");
        chk_cnt(1, 4, "frz_cnt");

        // MD_LATENCY=4: mult then HI/LO readers; a second mult is not queued.
        do_reset();
        step(mk(PC_SEQ,0, 0,0, 0,0, 1,0, 0,0, 0), 6'b000000, 0, "md_c0");
        step(mk(PC_SEQ,0, 0,0, 0,0, 0,1, 0,0, 0), 6'b011101, 0, "md_c1");
        step(mk(PC_SEQ,0, 0,0, 0,0, 1,0, 0,0, 0), 6'b011101, 0, "md_c2");
        step(mk(PC_SEQ,0, 0,0, 0,0, 0,1, 0,0, 0), 6'b011101, 0, "md_c3");
        step(mk(PC_SEQ,0, 0,0, 0,0, 0,1, 0,0, 0), 6'b000000, 0, "md_c4");
        chk_cnt(0, 3, "md_cnt");

        // Reset mid-BUSY with a pending load on LOAD_LATENCY=3.
        do_reset();
        step(mk(PC_SEQ,0, 0,0, 0,0, 1,0, 0,0, 0), 6'b000000, 2, "mr_start");
        step(mk(PC_SEQ,0, 0,0, 0,0, 0,0, 10,1, 0), 6'b000001, 2, "mr_load");
        step(mk(PC_SEQ,0, 10,1, 0,0, 0,1, 0,0, 0), 6'b011101, 2, "mr_pre");
        reset = 1'b1;
        step(mk(PC_SEQ,0, 10,1, 0,0, 0,1, 0,0, 0), 6'b000000, 2, "mr_in_rst");
        chk_cnt(2, 0, "mr_cnt");
        reset = 1'b0;
        step(mk(PC_SEQ,0, 10,1, 0,0, 0,1, 0,0, 0), 6'b000000, 2, "mr_post");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS pipeline, next generation of the combinational hazard unit. It detects load-use hazards against multi-cycle data memory, multiply/divide busy hazards on HI/LO, jump and branch flushes, and whole-pipeline memory-wait freezes. Internal state covers a pending-load scoreboard, a mult/div busy FSM and a stall-cycle performance counter. It sits beside the ID stage and drives the PC and the IF/ID and ID/EX pipeline-register controls.

Parameters:
LOAD_LATENCY, 1, data-memory read latency in cycles (≥1); 1 gives classic single-bubble load-use behaviour
MD_LATENCY, 4, mult/div execution cycles (≥1)
REG_W, 5, register address width
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
PCSrc  in  3  PC source select; 2/3 = jump/jr, 1 = branch target
Branch  in  1  branch in ID resolved taken
ID_Rs  in  REG_W  ID source register rs
ID_Rt  in  REG_W  ID source register rt
ID_UseRs  in  1  ID instruction reads rs
ID_UseRt  in  1  ID instruction reads rt
ID_MulDiv  in  1  ID instruction starts mult/div
ID_ReadHiLo  in  1  ID instruction is mfhi/mflo
EX_Rt  in  REG_W  destination of the instruction in EX
EX_MemRd  in  1  EX instruction is a load
Mem_Busy  in  1  data memory not ready
IF_ID_Stall  out  1  flush IF/ID to a bubble
IF_ID_Hold  out  1  hold IF/ID
ID_EX_Stall  out  1  insert a bubble into ID/EX
PCHold  out  1  hold PC
PipeFreeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB
MD_Busy  out  1  mult/div FSM in BUSY (registered)
StallCycles  out  CNT_W  count of cycles with PCHold=1 (registered)

Behaviour:
- Reset (async, active-high): scoreboard cleared, FSM to IDLE, counter cleared. While reset is high, all outputs are 0.
- Control outputs are combinational from inputs and state, with zero latency. MD_Busy and StallCycles are registered.
- Scoreboard: LOAD_LATENCY-1 entries of {valid, reg}. It does not exist when LOAD_LATENCY=1.
  - Each cycle without PipeFreeze: shift by one. Entry 0 loads {EX_MemRd && EX_Rt!=0, EX_Rt}. The last entry is discarded.
  - Under PipeFreeze: no shift.
- Source match: (ID_UseRs && ID_Rs==R) || (ID_UseRt && ID_Rt==R). Register 0 never matches.
- LoadHaz: EX_MemRd matches with R=EX_Rt, or any valid scoreboard entry matches its reg.
- MDHaz: MD_Busy && (ID_MulDiv || ID_ReadHiLo).
- Priority, highest first:
  1. Mem_Busy: PipeFreeze=1, PCHold=1, IF_ID_Hold=1; all others 0.
  2. LoadHaz or MDHaz: PCHold=1, IF_ID_Hold=1, ID_EX_Stall=1, IF_ID_Stall=0.
  3. PCSrc==2 or PCSrc==3: IF_ID_Stall=1.
  4. PCSrc==1 or Branch: IF_ID_Stall=1.
  5. Otherwise: all 0.
- A stall overrides a flush in the same cycle. The branch or jump re-resolves after the stall clears.
- Mult/div FSM:
  - IDLE→BUSY when ID_MulDiv, no stall and no freeze. Counter loads MD_LATENCY-1.
  - In BUSY, the counter decrements every cycle, including under freeze, because the unit runs independently.
  - BUSY→IDLE when the counter is 0 at a clock edge.
  - MD_LATENCY=1: the FSM never leaves IDLE.
  - A new mult/div in ID while BUSY stalls (MDHaz). It is not queued.
- StallCycles: increments when PCHold=1; wraps at 2^CNT_W.
- Reset mid-operation: pending loads and the BUSY state are dropped immediately.

Decomposition:
- Shared package: the PCSrc encodings (PC_SEQ=0, PC_BR=1, PC_J=2, PC_JR=3), FSM state constants MD_IDLE/MD_BUSY, and REG_W.
- One natural sub-module: load_scoreboard, holding the shift register and the match logic and producing LoadHaz.

Test Plan:
- LOAD_LATENCY=1: EX_MemRd=1, EX_Rt=8, ID_UseRs=1, ID_Rs=8 → PCHold=IF_ID_Hold=ID_EX_Stall=1 for exactly 1 cycle. With EX_Rt=0, ID_Rs=0 → no stall.
- LOAD_LATENCY=3: load to $9 in EX, consumer reads $9 → stall for 3 consecutive cycles, then clear; StallCycles=3.
- Freeze: hold Mem_Busy=1 for 2 cycles during a pending LOAD_LATENCY=2 load → PipeFreeze=1 and scoreboard frozen; the load-use stall resumes after release (2 more stall cycles).
- MD_LATENCY=4: mult accepted, then mflo in ID the next cycle → stall for 3 cycles; MD_Busy falls together with the stall.
- Priority: load-use hazard together with PCSrc=2 → IF_ID_Stall=0, ID_EX_Stall=1. Next cycle with no hazard and PCSrc=2 → IF_ID_Stall=1 only. Branch=1 alone → IF_ID_Stall=1.
- Assert reset mid-BUSY with a valid scoreboard entry → all outputs 0 immediately. After release, a consumer of that register does not stall and MD_Busy=0.
